// File: rtl/mul4_pkg.sv
// Shared types, widths and the round-robin pick helper for the shared 4x4 multiplier.
package mul4_pkg;

  localparam int OPW    = 4;
  localparam int PW     = 8;
  localparam int MAXREQ = 8;

  typedef enum logic [1:0] {IDLE, MUL, RESP} state_t;

  // First set bit of valid scanning upward from ptr with wrap at nreq.
  function automatic logic [2:0] rr_pick(input logic [MAXREQ-1:0] valid,
                                         input logic [2:0]        ptr,
                                         input int                nreq);
    logic [2:0] pick;
    int         idx;
    pick = ptr;
    idx  = 0;
    for (int k = MAXREQ - 1; k >= 0; k--) begin
      if (k < nreq) begin
        idx = (int'(ptr) + k) % nreq;
        if (valid[idx[2:0]]) pick = idx[2:0];
      end
    end
    return pick;
  endfunction

endpackage

// File: rtl/mul4_array.sv
// Combinational 4x4 unsigned ripple array multiplier built from half/full adder cells.
module mul4_array
  import mul4_pkg::*;
(
  input  logic [OPW-1:0] a,
  input  logic [OPW-1:0] b,
  output logic [PW-1:0]  p
);

  logic [3:0][3:0] pp;
  logic [3:0][4:0] row;
  logic            carry;
  logic            x;
  logic            y;

  // Each row adds the next partial product to the upper bits of the previous row.
  always_comb begin
    pp    = '0;
    row   = '0;
    carry = 1'b0;
    x     = 1'b0;
    y     = 1'b0;
    for (int i = 0; i < 4; i++) begin
      for (int j = 0; j < 4; j++) begin
        pp[i][j] = a[j] & b[i];
      end
    end
    row[0] = {1'b0, pp[0]};
    for (int i = 1; i < 4; i++) begin
      carry = 1'b0;
      for (int j = 0; j < 4; j++) begin
        x         = pp[i][j];
        y         = row[i-1][j+1];
        row[i][j] = x ^ y ^ carry;
        carry     = (x & y) | (carry & (x ^ y));
      end
      row[i][4] = carry;
    end
    p = {row[3], row[2][0], row[1][0], row[0][0]};
  end

endmodule

// File: rtl/mul4_share_ctrl.sv
// Round-robin sequencer sharing one 4x4 array multiplier among NREQ requesters,
// with registered operands/product and a wrapping completion counter.
module mul4_share_ctrl
  import mul4_pkg::*;
#(
  parameter int NREQ = 4,
  parameter int IDW  = (NREQ > 2) ? $clog2(NREQ) : 1,
  parameter int CNTW = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [NREQ-1:0]   req_valid,
  output logic [NREQ-1:0]   req_ready,
  input  logic [4*NREQ-1:0] req_a,
  input  logic [4*NREQ-1:0] req_b,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [PW-1:0]     rsp_p,
  output logic [IDW-1:0]    rsp_id,
  output logic              busy,
  output logic [CNTW-1:0]   done_cnt
);

  state_t            state;
  state_t            state_nx;
  logic [IDW-1:0]    rr_ptr;
  logic [IDW-1:0]    grant;
  logic [IDW-1:0]    ptr_nx;
  logic [OPW-1:0]    a_r;
  logic [OPW-1:0]    b_r;
  logic [IDW-1:0]    id_r;
  logic [PW-1:0]     p_r;
  logic [PW-1:0]     prod;
  logic [OPW-1:0]    a_sel;
  logic [OPW-1:0]    b_sel;
  logic [MAXREQ-1:0] valid_ext;
  logic [2:0]        ptr_ext;
  logic              take;
  logic              rsp_fire;

  assign valid_ext = MAXREQ'(req_valid);
  assign ptr_ext   = 3'(rr_ptr);
  assign grant     = IDW'(rr_pick(valid_ext, ptr_ext, NREQ));
  assign ptr_nx    = (grant == IDW'(NREQ - 1)) ? '0 : grant + 1'b1;
  assign a_sel     = req_a[int'(grant)*OPW +: OPW];
  assign b_sel     = req_b[int'(grant)*OPW +: OPW];
  assign rsp_fire  = (state == RESP) && rsp_ready;

  mul4_array u_mul (
    .a (a_r),
    .b (b_r),
    .p (prod)
  );

  // A grant can happen from IDLE, or from RESP in the same cycle the consumer takes the product.
  always_comb begin
    state_nx  = state;
    take      = 1'b0;
    req_ready = '0;
    unique case (state)
      IDLE: begin
        if (|req_valid) begin
          take     = 1'b1;
          state_nx = MUL;
        end
      end
      MUL: state_nx = RESP;
      RESP: begin
        if (rsp_ready) begin
          if (|req_valid) begin
            take     = 1'b1;
            state_nx = MUL;
          end else begin
            state_nx = IDLE;
          end
        end
      end
      default: state_nx = IDLE;
    endcase
    if (take) req_ready[grant] = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      rr_ptr   <= '0;
      a_r      <= '0;
      b_r      <= '0;
      id_r     <= '0;
      p_r      <= '0;
      done_cnt <= '0;
    end else begin
      state <= state_nx;
      if (take) begin
        a_r    <= a_sel;
        b_r    <= b_sel;
        id_r   <= grant;
        rr_ptr <= ptr_nx;
      end
      if (state == MUL) p_r <= prod;
      if (rsp_fire) done_cnt <= done_cnt + CNTW'(1);
    end
  end

  assign rsp_valid = (state == RESP);
  assign rsp_p     = p_r;
  assign rsp_id    = id_r;
  assign busy      = (state != IDLE);

endmodule

// File: tb/tb_mul4_share_ctrl.sv
// Self-checking bench for mul4_share_ctrl: reference model plus scoreboard, vector table and corner sequences.
module tb_mul4_share_ctrl;

  logic        clk;
  logic        rst_n;
  logic [3:0]  req_valid;
  logic [3:0]  req_ready;
  logic [15:0] req_a;
  logic [15:0] req_b;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [7:0]  rsp_p;
  logic [1:0]  rsp_id;
  logic        busy;
  logic [3:0]  done_cnt;

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic [1:0] id;
    logic [7:0] p;
  } exp_t;

  typedef struct {
    int         req;
    logic [3:0] a;
    logic [3:0] b;
    int         hold;
    logic [7:0] expP;
    logic [1:0] expId;
  } vec_t;

  exp_t sb[$];

  mul4_share_ctrl #(.NREQ(4), .IDW(2), .CNTW(4)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_a     (req_a),
    .req_b     (req_b),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_p     (rsp_p),
    .rsp_id    (rsp_id),
    .busy      (busy),
    .done_cnt  (done_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int pickModel(input logic [3:0] v, input int ptr);
    for (int k = 0; k < 4; k++) begin
      if (v[(ptr + k) % 4]) return (ptr + k) % 4;
    end
    return 0;
  endfunction

  // Reference model: 0=idle, 1=multiply, 2=response; updated once per cycle at the falling edge.
  int         mState = 0;
  int         mPtr   = 0;
  logic [3:0] mCnt   = '0;

  always @(negedge clk) begin
    int         g;
    logic       grantEn;
    logic [3:0] expReady;
    exp_t       e;
    if (!rst_n) begin
      mState = 0;
      mPtr   = 0;
      mCnt   = '0;
      sb.delete();
    end else begin
      g        = pickModel(req_valid, mPtr);
      grantEn  = (|req_valid) && (mState == 0 || (mState == 2 && rsp_ready));
      expReady = grantEn ? (4'b0001 << g) : 4'b0000;
      checkOutput("req_ready", req_ready, expReady);
      checkOutput("rsp_valid", rsp_valid, mState == 2);
      checkOutput("busy", busy, mState != 0);
      checkOutput("done_cnt", done_cnt, mCnt);
      if (mState == 2 && rsp_ready) begin
        if (sb.size() == 0) begin
          checkOutput("sb_underflow", 1, 0);
        end else begin
          e = sb.pop_front();
          checkOutput("sb_p", rsp_p, e.p);
          checkOutput("sb_id", rsp_id, e.id);
        end
        mCnt = mCnt + 4'd1;
      end
      if (grantEn) begin
        e.id = 2'(g);
        e.p  = 8'(req_a[4*g +: 4]) * 8'(req_b[4*g +: 4]);
        sb.push_back(e);
        mPtr = (g + 1) % 4;
      end
      case (mState)
        0:       mState = grantEn ? 1 : 0;
        1:       mState = 2;
        default: mState = rsp_ready ? (grantEn ? 1 : 0) : 2;
      endcase
    end
  end

  task automatic applyStimulus(input int r, input logic [3:0] a, input logic [3:0] b);
    @(posedge clk);
    #1;
    req_valid          = 4'b0001 << r;
    req_a[4*r +: 4]    = a;
    req_b[4*r +: 4]    = b;
  endtask

  task automatic waitAccept(input int r);
    logic seen;
    seen = 1'b0;
    for (int c = 0; c < 10 && !seen; c++) begin
      @(negedge clk);
      if (req_ready[r]) seen = 1'b1;
    end
    checkOutput("accept_timeout", seen, 1);
  endtask

  task automatic dropRequests();
    @(posedge clk);
    #1;
    req_valid = '0;
  endtask

  task automatic doReset();
    @(posedge clk);
    #1;
    rst_n     = 1'b0;
    req_valid = '0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  task automatic doOp(input int r, input logic [3:0] a, input logic [3:0] b, input int expCnt);
    logic seen;
    applyStimulus(r, a, b);
    waitAccept(r);
    dropRequests();
    seen = 1'b0;
    for (int c = 0; c < 10 && !seen; c++) begin
      @(negedge clk);
      if (rsp_valid && rsp_ready) seen = 1'b1;
    end
    checkOutput("rsp_timeout", seen, 1);
    @(negedge clk);
    checkOutput("op_count", done_cnt, expCnt % 16);
  endtask

  initial begin
    vec_t       vecs[5];
    int         opCount;
    int         lat;
    logic       found;
    logic [1:0] expIds[5];
    logic [7:0] expPs[5];
    logic [1:0] gotIds[5];
    logic [7:0] gotPs[5];
    int         gotCyc[5];
    int         nGot;
    int         seenRsp;
    int         seen25;

    vecs[0] = '{req: 0, a: 4'd15, b: 4'd15, hold: 0, expP: 8'hE1, expId: 2'd0};
    vecs[1] = '{req: 2, a: 4'd9,  b: 4'd7,  hold: 5, expP: 8'd63, expId: 2'd2};
    vecs[2] = '{req: 1, a: 4'd0,  b: 4'd13, hold: 0, expP: 8'd0,  expId: 2'd1};
    vecs[3] = '{req: 3, a: 4'd12, b: 4'd0,  hold: 2, expP: 8'd0,  expId: 2'd3};
    vecs[4] = '{req: 1, a: 4'd7,  b: 4'd8,  hold: 1, expP: 8'd56, expId: 2'd1};
    expIds  = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};
    expPs   = '{8'd3, 8'd6, 8'd9, 8'd12, 8'd3};

    rst_n     = 1'b0;
    req_valid = '0;
    req_a     = '0;
    req_b     = '0;
    rsp_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checkOutput("rst_rsp_valid", rsp_valid, 0);
    checkOutput("rst_req_ready", req_ready, 0);
    checkOutput("rst_busy", busy, 0);
    checkOutput("rst_done_cnt", done_cnt, 0);
    checkOutput("rst_rsp_p", rsp_p, 0);
    checkOutput("rst_rsp_id", rsp_id, 0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    $display("[TB] vector table");
    opCount = 0;
    for (int v = 0; v < 5; v++) begin
      applyStimulus(vecs[v].req, vecs[v].a, vecs[v].b);
      rsp_ready = (vecs[v].hold == 0);
      waitAccept(vecs[v].req);
      @(posedge clk);
      #1;
      req_valid = (vecs[v].hold > 0) ? (4'b0001 << ((vecs[v].req + 1) % 4)) : 4'b0000;
      lat   = 0;
      found = 1'b0;
      for (int c = 0; c < 10 && !found; c++) begin
        @(negedge clk);
        lat++;
        if (rsp_valid) found = 1'b1;
      end
      checkOutput("rsp_timeout", found, 1);
      checkOutput("latency", lat, 2);
      if (vecs[v].hold > 0) begin
        for (int h = 0; h < vecs[v].hold; h++) begin
          if (h > 0) @(negedge clk);
          checkOutput("hold_p", rsp_p, vecs[v].expP);
          checkOutput("hold_id", rsp_id, vecs[v].expId);
          checkOutput("hold_ready", req_ready, 0);
        end
        @(posedge clk);
        #1;
        rsp_ready = 1'b1;
        req_valid = '0;
        @(negedge clk);
      end
      checkOutput("tbl_p", rsp_p, vecs[v].expP);
      checkOutput("tbl_id", rsp_id, vecs[v].expId);
      opCount++;
      @(negedge clk);
      checkOutput("tbl_done_cnt", done_cnt, opCount);
    end

    $display("[TB] rotation with all requesters");
    doReset();
    @(posedge clk);
    #1;
    rsp_ready = 1'b1;
    req_a     = {4'd4, 4'd3, 4'd2, 4'd1};
    req_b     = {4'd3, 4'd3, 4'd3, 4'd3};
    req_valid = 4'hF;
    nGot = 0;
    for (int c = 0; c < 40 && nGot < 5; c++) begin
      @(negedge clk);
      if (rsp_valid && rsp_ready) begin
        gotIds[nGot] = rsp_id;
        gotPs[nGot]  = rsp_p;
        gotCyc[nGot] = c;
        nGot++;
      end
    end
    checkOutput("rot_count", nGot, 5);
    for (int k = 0; k < nGot; k++) begin
      checkOutput("rot_id", gotIds[k], expIds[k]);
      checkOutput("rot_p", gotPs[k], expPs[k]);
      if (k > 0) checkOutput("rot_spacing", gotCyc[k] - gotCyc[k-1], 2);
    end
    dropRequests();
    repeat (6) @(posedge clk);

    $display("[TB] reset during multiply");
    applyStimulus(0, 4'd5, 4'd5);
    rsp_ready = 1'b1;
    waitAccept(0);
    dropRequests();
    #1;
    rst_n = 1'b0;
    #1;
    checkOutput("mid_rsp_valid", rsp_valid, 0);
    checkOutput("mid_req_ready", req_ready, 0);
    checkOutput("mid_busy", busy, 0);
    checkOutput("mid_done_cnt", done_cnt, 0);
    checkOutput("mid_rsp_p", rsp_p, 0);
    checkOutput("mid_rsp_id", rsp_id, 0);
    repeat (2) @(posedge clk);
    #1;
    rst_n   = 1'b1;
    seenRsp = 0;
    seen25  = 0;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      if (rsp_valid) seenRsp++;
      if (rsp_valid && rsp_p == 8'd25) seen25++;
    end
    checkOutput("dropped_rsp", seenRsp, 0);
    checkOutput("dropped_25", seen25, 0);

    $display("[TB] exhaustive products on requester 1");
    rsp_ready = 1'b1;
    for (int n = 0; n < 256; n++) begin
      applyStimulus(1, 4'(n >> 4), 4'(n));
      waitAccept(1);
    end
    dropRequests();
    repeat (6) @(posedge clk);

    $display("[TB] counter wrap");
    doReset();
    for (int i = 0; i < 16; i++) begin
      doOp(3, 4'(i), 4'd1, i + 1);
      if (i == 14) checkOutput("cnt_max", done_cnt, 15);
      if (i == 15) checkOutput("cnt_wrap", done_cnt, 0);
    end
    repeat (3) @(posedge clk);
    checkOutput("sb_leftover", sb.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
